// File: rtl/reg_banq_seq.sv
// Instruction sequencer for the complex register bank: decodes 32-bit instructions,
// issues a bank read, optionally runs the external ALU, then schedules the writeback.
module reg_banq_seq #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic             enrregA,
    output logic             enrregB,
    output logic [3:0]       seloutA,
    output logic [3:0]       seloutB,
    output logic             cnstA,
    output logic             cnstB,
    output logic             regwen,
    output logic [3:0]       selwreg,
    output logic [1:0]       endwreg,
    output logic             wb_sel,
    output logic             alu_start,
    output logic [3:0]       alu_op,
    input  logic             alu_done,
    input  logic             resume,
    output logic             busy,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TO_W = $clog2(TIMEOUT);
    localparam logic [3:0]  OP_NOP  = 4'd0;
    localparam logic [3:0]  OP_MOVA = 4'd1;
    localparam logic [3:0]  OP_HALT = 4'd15;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] dest;
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic       c_a;
        logic       c_b;
        logic [1:0] endw;
    } fields_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    fields_t           fld_q, fld_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              ret_inc, err_set;
    logic              instr_ready_d, enrreg_d, regwen_d, alu_start_d;
    logic              busy_d, halted_d, wb_sel_d;
    logic              instr_unused;

    assign instr_unused = ^instr[11:0];

    // Latched fields drive the bank/ALU selects directly between accepts.
    assign seloutA = fld_q.src_a;
    assign seloutB = fld_q.src_b;
    assign cnstA   = fld_q.c_a;
    assign cnstB   = fld_q.c_b;
    assign selwreg = fld_q.dest;
    assign endwreg = fld_q.endw;
    assign alu_op  = fld_q.op;

    // Next state plus next-cycle values of the state-decoded outputs.
    always_comb begin
        state_d       = state_q;
        fld_d         = fld_q;
        tcnt_d        = tcnt_q;
        ret_inc       = 1'b0;
        err_set       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    fld_d = fields_t'(instr[31:12]);
                    case (instr[31:28])
                        OP_NOP:  ret_inc = 1'b1;
                        OP_HALT: begin
                            ret_inc = 1'b1;
                            state_d = S_HALTED;
                        end
                        default: state_d = S_READ;
                    endcase
                end
            end
            S_READ:  state_d = S_ISSUE;
            S_ISSUE: begin
                if (fld_q.op == OP_MOVA) begin
                    state_d = S_WB;
                end else begin
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done on the final allowed cycle still wins over the abort.
                if (alu_done) begin
                    state_d = S_WB;
                end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            S_WB: begin
                ret_inc = 1'b1;
                state_d = S_IDLE;
            end
            S_HALTED: begin
                if (resume) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        instr_ready_d = (state_d == S_IDLE);
        enrreg_d      = (state_d == S_READ);
        regwen_d      = (state_d == S_WB);
        alu_start_d   = (state_d == S_ISSUE) && (fld_d.op != OP_MOVA);
        busy_d        = (state_d != S_IDLE) && (state_d != S_HALTED);
        halted_d      = (state_d == S_HALTED);
        wb_sel_d      = (fld_d.op > OP_MOVA) && (fld_d.op < OP_HALT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fld_q       <= '0;
            tcnt_q      <= '0;
            retired     <= '0;
            err_timeout <= 1'b0;
            instr_ready <= 1'b1;
            enrregA     <= 1'b0;
            enrregB     <= 1'b0;
            regwen      <= 1'b0;
            alu_start   <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            wb_sel      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fld_q       <= fld_d;
            tcnt_q      <= tcnt_d;
            if (ret_inc) retired <= retired + CNT_W'(1);
            if (err_set) err_timeout <= 1'b1;
            instr_ready <= instr_ready_d;
            enrregA     <= enrreg_d;
            enrregB     <= enrreg_d;
            regwen      <= regwen_d;
            alu_start   <= alu_start_d;
            busy        <= busy_d;
            halted      <= halted_d;
            wb_sel      <= wb_sel_d;
        end
    end

endmodule
